// File: rtl/key_debounce_if.sv
// Key-pin and qualified-key-event bundle between the board pins and the key debouncer.
// The master drives the raw pins and consumes the events; the slave is the debouncer.
interface key_debounce_if #(
  parameter int NUM_KEYS = 5
);
  logic [NUM_KEYS-1:0] i_key;
  logic [NUM_KEYS-1:0] o_key_level;
  logic [NUM_KEYS-1:0] o_key_press;
  logic [NUM_KEYS-1:0] o_key_release;
  logic [NUM_KEYS-1:0] o_key_long;
  logic [NUM_KEYS-1:0] o_key_repeat;

  modport master (
    output i_key,
    input  o_key_level, o_key_press, o_key_release, o_key_long, o_key_repeat
  );

  modport slave (
    input  i_key,
    output o_key_level, o_key_press, o_key_release, o_key_long, o_key_repeat
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button qualifier: two-flop synchroniser, per-key debounce counter and a
// hold FSM producing press/release/long/repeat pulses. Keys are fully independent.
module key_debounce #(
  parameter int NUM_KEYS      = 5,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic         i_clk,
  input logic         i_rst_n,
  key_debounce_if.slave keys
);
  localparam int DCW      = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HCW      = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_st_e;

  logic [NUM_KEYS-1:0] sync1_r;
  logic [NUM_KEYS-1:0] sync2_r;
  logic [NUM_KEYS-1:0] level_s;
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] release_s;
  logic [NUM_KEYS-1:0] long_v_s;
  logic [NUM_KEYS-1:0] repeat_v_s;

  // Pin synchroniser; idles at the released (high) pin level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= keys.i_key;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic           p_s;
    logic           accept_s;
    logic           press_evt_s;
    logic           rel_evt_s;
    logic [DCW-1:0] dcnt_r;
    logic           level_r;
    logic           press_r;
    logic           release_r;
    hold_st_e       state_r;
    hold_st_e       state_s;
    logic [HCW-1:0] hcnt_r;
    logic [HCW-1:0] hcnt_s;
    logic           long_s;
    logic           repeat_s;
    logic           long_r;
    logic           repeat_r;

    assign p_s         = ~sync2_r[g];
    assign accept_s    = (p_s != level_r) && (dcnt_r == DCW'(DEB_CYCLES - 1));
    assign press_evt_s = accept_s & p_s;
    assign rel_evt_s   = accept_s & ~p_s;

    // Debounce counter: any return to the accepted level restarts the run.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        dcnt_r    <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        press_r   <= press_evt_s;
        release_r <= rel_evt_s;
        if (p_s == level_r) begin
          dcnt_r <= '0;
        end else if (accept_s) begin
          level_r <= p_s;
          dcnt_r  <= '0;
        end else begin
          dcnt_r <= dcnt_r + DCW'(1);
        end
      end
    end

    // Hold FSM state register with registered long/repeat pulses.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state_r  <= ST_IDLE;
        hcnt_r   <= '0;
        long_r   <= 1'b0;
        repeat_r <= 1'b0;
      end else begin
        state_r  <= state_s;
        hcnt_r   <= hcnt_s;
        long_r   <= long_s;
        repeat_r <= repeat_s;
      end
    end

    // Hold FSM next state; an accepted release always wins.
    always_comb begin
      state_s = state_r;
      hcnt_s  = hcnt_r;
      if (rel_evt_s) begin
        state_s = ST_IDLE;
        hcnt_s  = '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (press_evt_s) begin
              state_s = ST_HELD;
            end else begin
              state_s = ST_IDLE;
            end
            hcnt_s = '0;
          end
          ST_HELD: begin
            if (hcnt_r == HCW'(LONG_CYCLES - 1)) begin
              state_s = ST_REPEAT;
              hcnt_s  = '0;
            end else begin
              hcnt_s = hcnt_r + HCW'(1);
            end
          end
          ST_REPEAT: begin
            if (hcnt_r == HCW'(REPEAT_CYCLES - 1)) begin
              hcnt_s = '0;
            end else begin
              hcnt_s = hcnt_r + HCW'(1);
            end
          end
          default: begin
            state_s = ST_IDLE;
            hcnt_s  = '0;
          end
        endcase
      end
    end

    // Hold FSM outputs, suppressed when a release lands on the same edge.
    always_comb begin
      long_s   = 1'b0;
      repeat_s = 1'b0;
      if (rel_evt_s) begin
        long_s   = 1'b0;
        repeat_s = 1'b0;
      end else begin
        case (state_r)
          ST_HELD:   long_s   = (hcnt_r == HCW'(LONG_CYCLES - 1));
          ST_REPEAT: repeat_s = (hcnt_r == HCW'(REPEAT_CYCLES - 1));
          default: begin
            long_s   = 1'b0;
            repeat_s = 1'b0;
          end
        endcase
      end
    end

    assign level_s[g]    = level_r;
    assign press_s[g]    = press_r;
    assign release_s[g]  = release_r;
    assign long_v_s[g]   = long_r;
    assign repeat_v_s[g] = repeat_r;
  end

  assign keys.o_key_level   = level_s;
  assign keys.o_key_press   = press_s;
  assign keys.o_key_release = release_s;
  assign keys.o_key_long    = long_v_s;
  assign keys.o_key_repeat  = repeat_v_s;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected pulse events are queued by cycle when
// stimulus is driven and compared every cycle against the DUT outputs.
module tb_key_debounce;
  localparam int NK   = 5;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  // Drive at cycle t -> sync1 captures at t+1 -> press/release registered DEB+1 later.
  localparam int LAT  = DEB + 2;

  typedef struct {
    int          cyc;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;
    logic [NK-1:0] rp;
  } ev_t;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  int            cyc     = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  ev_t           q[$];
  logic [NK-1:0] exp_level = '0;
  string         phase = "reset";
  int            t;
  int            p;
  int            r;

  key_debounce_if #(.NUM_KEYS(NK)) kif();

  key_debounce #(
    .NUM_KEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .keys   (kif)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s cyc=%0d observed=%b expected=%b", phase, tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                      input logic [NK-1:0] lg, input logic [NK-1:0] rp);
    ev_t e;
    int  idx;
    idx = 0;
    while (idx < q.size() && q[idx].cyc < c) idx++;
    if (idx < q.size() && q[idx].cyc == c) begin
      e    = q[idx];
      e.pr = e.pr | pr;
      e.rl = e.rl | rl;
      e.lg = e.lg | lg;
      e.rp = e.rp | rp;
      q[idx] = e;
    end else begin
      e.cyc = c;
      e.pr  = pr;
      e.rl  = rl;
      e.lg  = lg;
      e.rp  = rp;
      q.insert(idx, e);
    end
  endtask

  task automatic check_cycle();
    ev_t e;
    e.cyc = cyc;
    e.pr  = '0;
    e.rl  = '0;
    e.lg  = '0;
    e.rp  = '0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      exp_level = (exp_level | e.pr) & ~e.rl;
    end
    chk("press",   kif.o_key_press,   e.pr);
    chk("release", kif.o_key_release, e.rl);
    chk("long",    kif.o_key_long,    e.lg);
    chk("repeat",  kif.o_key_repeat,  e.rp);
    chk("level",   kif.o_key_level,   exp_level);
    chk("excl",    kif.o_key_press & kif.o_key_release, 5'b00000);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      check_cycle();
    end
  endtask

  initial begin
    kif.i_key = 5'b11111;
    i_rst_n   = 1'b0;
    tick(2);
    chk("rst_all", kif.o_key_level | kif.o_key_press | kif.o_key_release |
                   kif.o_key_long | kif.o_key_repeat, 5'b00000);
    i_rst_n = 1'b1;
    tick(3);

    phase = "clean";
    kif.i_key[0] = 1'b0;
    t = cyc;
    push(t + LAT, 5'b00001, 5'b00000, 5'b00000, 5'b00000);
    tick(8);
    kif.i_key[0] = 1'b1;
    t = cyc;
    push(t + LAT, 5'b00000, 5'b00001, 5'b00000, 5'b00000);
    tick(10);

    phase = "bounce";
    kif.i_key[1] = 1'b0;
    tick(3);
    kif.i_key[1] = 1'b1;
    tick(1);
    kif.i_key[1] = 1'b0;
    tick(3);
    kif.i_key[1] = 1'b1;
    tick(10);
    kif.i_key[1] = 1'b0;
    t = cyc;
    push(t + LAT, 5'b00010, 5'b00000, 5'b00000, 5'b00000);
    tick(10);
    kif.i_key[1] = 1'b1;
    t = cyc;
    push(t + LAT, 5'b00000, 5'b00010, 5'b00000, 5'b00000);
    tick(10);

    // Release lands exactly when a fifth repeat would be due.
    phase = "long_rep";
    kif.i_key[2] = 1'b0;
    t = cyc;
    p = t + LAT;
    push(p, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    push(p + LONG, 5'b00000, 5'b00000, 5'b00100, 5'b00000);
    for (int k = 1; k <= 4; k++)
      push(p + LONG + k * REP, 5'b00000, 5'b00000, 5'b00000, 5'b00100);
    tick(LAT + LONG + 4 * REP + 2);
    kif.i_key[2] = 1'b1;
    push(p + LONG + 5 * REP, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
    tick(25);

    phase = "rel_beats_long";
    kif.i_key[3] = 1'b0;
    t = cyc;
    p = t + LAT;
    push(p, 5'b01000, 5'b00000, 5'b00000, 5'b00000);
    tick(LAT + LONG - LAT);
    kif.i_key[3] = 1'b1;
    push(p + LONG, 5'b00000, 5'b01000, 5'b00000, 5'b00000);
    tick(40);

    phase = "simultaneous";
    kif.i_key = 5'b00000;
    t = cyc;
    push(t + LAT, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    push(t + LAT + LONG, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
    push(t + LAT + LONG + REP, 5'b00000, 5'b00000, 5'b00000, 5'b11111);
    tick(LAT + LONG + REP + 2);

    // Keys stay held through a one-cycle reset while in REPEAT.
    phase = "reset_mid";
    i_rst_n   = 1'b0;
    exp_level = '0;
    tick(1);
    r = cyc;
    chk("rst_mid", kif.o_key_level | kif.o_key_press | kif.o_key_release |
                   kif.o_key_long | kif.o_key_repeat, 5'b00000);
    i_rst_n = 1'b1;
    // Press returns DEB+3 edges counting the reset edge as the first.
    push(r + DEB + 2, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    push(r + DEB + 2 + LONG, 5'b00000, 5'b00000, 5'b11111, 5'b00000);
    push(r + DEB + 2 + LONG + REP, 5'b00000, 5'b00000, 5'b00000, 5'b11111);
    tick(DEB + 2 + LONG + REP + 2);
    kif.i_key = 5'b11111;
    t = cyc;
    push(t + LAT, 5'b00000, 5'b11111, 5'b00000, 5'b00000);
    tick(20);

    phase = "end";
    n_tests++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL pending_events observed=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
